// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and the enums used by the instruction encoder.
package rv_pkg;

    // Base opcodes, identical to the values the main decoder matches on
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_U    = 7'b0110111;

    // funct3 values forced for the fixed-function classes
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // Instruction class as carried on the input bundle
    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LW   = 3'd2,
        CLS_JALR = 3'd3,
        CLS_S    = 3'd4,
        CLS_B    = 3'd5,
        CLS_J    = 3'd6,
        CLS_U    = 3'd7
    } cls_e;

    // Session state of the encoder
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational packer: turns a decoded field bundle into one RV32I word.
// Immediate bits outside a format's range are simply not used.
module rv_imm_pack
    import rv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        align_err
);

    cls_e cls_e_val;
    assign cls_e_val = cls_e'(cls);

    // Select the bit layout of the requested format
    always_comb begin
        word      = '0;
        align_err = 1'b0;
        case (cls_e_val)
            CLS_R:    word = {funct7, rs2, rs1, funct3, rd, OP_R};
            CLS_I:    word = {imm[11:0], rs1, funct3, rd, OP_I};
            CLS_LW:   word = {imm[11:0], rs1, F3_LW, rd, OP_LW};
            CLS_JALR: word = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
            CLS_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
            CLS_B: begin
                word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
                align_err = imm[0];
            end
            CLS_J: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
                align_err = imm[0];
            end
            CLS_U:    word = {imm[31:12], rd, OP_U};
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: accepts field bundles, packs them and writes the
// words sequentially into instruction memory through a registered port.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  max_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_align,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_e             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [CNT_W-1:0]   acc_cnt_reg;
    logic [CNT_W-1:0]   limit_reg;
    logic               err_align_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [31:0]        mem_wdata_reg;
    logic [CNT_W-1:0]   word_count_reg;

    logic [31:0]        enc_word;
    logic               enc_align_err;
    logic               limit_hit;
    logic               xfer;
    logic               wr;
    logic               wr_hits_limit;
    logic               in_ready_next;
    logic               busy_next;
    logic               done_next;

    rv_imm_pack u_pack (
        .cls       (in_class),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .word      (enc_word),
        .align_err (enc_align_err)
    );

    // The limit counts words actually accepted for writing; a rejected
    // misaligned bundle does not consume a slot.
    assign limit_hit     = (limit_reg != '0) && (acc_cnt_reg == limit_reg);
    assign xfer          = in_valid && in_ready_next;
    assign wr            = xfer && !enc_align_err;
    assign wr_hits_limit = wr && (limit_reg != '0) && ((acc_cnt_reg + CNT_ONE) == limit_reg);

    // Next-state and state-decoded outputs
    always_comb begin
        state_next    = state_reg;
        in_ready_next = 1'b0;
        busy_next     = 1'b1;
        done_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_next = !limit_hit;
                if (in_valid && !limit_hit && (in_last || wr_hits_limit)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address/count bookkeeping and the registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            acc_cnt_reg    <= '0;
            limit_reg      <= '0;
            err_align_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            word_count_reg <= '0;
        end else begin
            mem_we_reg <= wr;
            if (wr) begin
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= enc_word;
                addr_reg      <= addr_reg + ADDR_STEP;
                acc_cnt_reg   <= acc_cnt_reg + CNT_ONE;
            end
            if (mem_we_reg) begin
                word_count_reg <= word_count_reg + CNT_ONE;
            end
            if (xfer && enc_align_err) begin
                err_align_reg <= 1'b1;
            end
            // A new session can only open from IDLE, where no write is in flight
            if ((state_reg == ST_IDLE) && start) begin
                addr_reg       <= base_addr & ADDR_MASK;
                acc_cnt_reg    <= '0;
                limit_reg      <= max_words;
                err_align_reg  <= 1'b0;
                word_count_reg <= '0;
            end
        end
    end

    assign in_ready   = in_ready_next;
    assign busy       = busy_next;
    assign done       = done_next;
    assign err_align  = err_align_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed sessions plus random
// sessions compared against a field-level reference model.
module tb_rv_instr_encoder;

    typedef struct packed {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] max_words = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [2:0]  in_class = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err_align;
    logic [15:0] word_count;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;
    logic [63:0] obs[$];
    int          obs_cyc[$];
    bundle_t     bq[$];

    rv_instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .max_words  (max_words),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err_align  (err_align),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write and done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            obs.push_back({mem_addr, mem_wdata});
            obs_cyc.push_back(cyc_cnt);
        end
        if (rst_n && done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bundle_t mk(input int cls, input int rd, input int rs1, input int rs2,
                                   input int f3, input int f7, input logic [31:0] imm, input bit last);
        bundle_t b;
        b.cls = 3'(cls); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
        b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = imm; b.last = last;
        return b;
    endfunction

    // Reference encoding: place each field by weight into the word
    function automatic logic [31:0] enc(input bundle_t b);
        int unsigned rd, rs1, rs2, f3, f7, im, w;
        rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; f3 = b.f3; f7 = b.f7; im = b.imm;
        w = 0;
        case (b.cls)
            3'd0: w = 'h33 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
            3'd1: w = 'h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((im % 4096) << 20);
            3'd2: w = 'h03 + (rd << 7) + (2 << 12) + (rs1 << 15) + ((im % 4096) << 20);
            3'd3: w = 'h67 + (rd << 7) + (rs1 << 15) + ((im % 4096) << 20);
            3'd4: w = 'h23 + ((im % 32) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
                      + (((im / 32) % 128) << 25);
            3'd5: w = 'h63 + (((im / 2048) % 2) << 7) + (((im / 2) % 16) << 8) + (f3 << 12)
                      + (rs1 << 15) + (rs2 << 20) + (((im / 32) % 64) << 25)
                      + (((im / 4096) % 2) << 31);
            3'd6: w = 'h6F + (rd << 7) + (((im / 4096) % 256) << 12) + (((im / 2048) % 2) << 20)
                      + (((im / 2) % 1024) << 21) + (((im / 1048576) % 2) << 31);
            default: w = 'h37 + (rd << 7) + ((im / 4096) << 12);
        endcase
        return w;
    endfunction

    function automatic logic [63:0] obs_at(input int idx);
        if (idx < obs.size()) return obs[idx];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic drive(input bundle_t b);
        in_class = b.cls; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm; in_last = b.last;
        in_valid = 1'b1;
    endtask

    // Runs one session over bq and compares against the model
    task automatic run_session(input string nm, input logic [31:0] base, input logic [15:0] maxw, input bit rnd);
        logic [63:0] exp_w[$];
        logic [31:0] a;
        int cnt, acc, nacc, cyc, d0;
        bit err;
        a = base & 32'hFFFF_FFFC; cnt = 0; acc = 0; err = 0;
        for (int i = 0; i < bq.size(); i++) begin
            if (maxw != 0 && cnt == maxw) break;
            acc++;
            if ((bq[i].cls == 3'd5 || bq[i].cls == 3'd6) && bq[i].imm[0]) begin
                err = 1;
            end else begin
                exp_w.push_back({a, enc(bq[i])});
                a = a + 32'd4;
                cnt++;
                if (maxw != 0 && cnt == maxw) break;
            end
            if (bq[i].last) break;
        end

        obs.delete(); obs_cyc.delete();
        @(negedge clk);
        start = 1'b1; base_addr = base; max_words = maxw;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        check({nm, "_err_clr"}, {63'd0, err_align}, 64'd0);
        nacc = 0;
        for (int i = 0; i < bq.size(); i++) begin
            if (rnd && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            drive(bq[i]);
            cyc = 0;
            while (!in_ready && busy && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (!in_ready) break;
            if (rnd && ($urandom_range(0, 3) == 0)) begin
                start = 1'b1; base_addr = $urandom; max_words = 16'($urandom_range(0, 3));
            end
            @(negedge clk);
            start = 1'b0;
            nacc++;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_end_timeout"}, {63'd0, busy}, 64'd0);
        check({nm, "_accepted"}, 64'(nacc), 64'(acc));
        check({nm, "_nwrites"}, 64'(obs.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) check({nm, "_write"}, obs_at(i), exp_w[i]);
        check({nm, "_word_count"}, 64'(word_count), 64'(exp_w.size()));
        check({nm, "_err_align"}, {63'd0, err_align}, {63'd0, err});
        check({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({nm, "_we_idle"}, {63'd0, mem_we}, 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err_align}, 64'd0);
        check("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single R-type word
        bq.delete();
        bq.push_back(mk(0, 3, 1, 2, 0, 0, 0, 1));
        run_session("r_single", 32'h100, 0, 0);
        check("r_single_lit", obs_at(0), {32'h100, 32'h002081B3});

        // Back-to-back streaming
        bq.delete();
        bq.push_back(mk(1, 1, 0, 0, 0, 0, 5, 0));
        bq.push_back(mk(2, 5, 2, 0, 7, 0, 8, 0));
        bq.push_back(mk(4, 0, 2, 5, 2, 0, 12, 1));
        run_session("stream", 32'h0, 0, 0);
        check("stream_w0", obs_at(0), {32'h0, 32'h00500093});
        check("stream_w1", obs_at(1), {32'h4, 32'h00812283});
        check("stream_w2", obs_at(2), {32'h8, 32'h00512623});
        check("stream_b2b", 64'((obs_cyc.size() == 3) ? obs_cyc[2] - obs_cyc[0] : -1), 64'd2);

        // B / U / J formats
        bq.delete();
        bq.push_back(mk(5, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 0));
        bq.push_back(mk(7, 7, 0, 0, 0, 0, 32'h1234_5000, 0));
        bq.push_back(mk(6, 1, 0, 0, 0, 0, 32'h0000_0800, 1));
        run_session("fmt", 32'h40, 0, 0);
        check("fmt_b", {32'd0, obs_at(0)[31:0]}, 64'h0000_0000_FE20_8EE3);
        check("fmt_u", {32'd0, obs_at(1)[31:0]}, 64'h0000_0000_1234_53B7);
        check("fmt_j", {32'd0, obs_at(2)[31:0]}, 64'h0000_0000_0010_00EF);

        // Misaligned branch between two good words
        bq.delete();
        bq.push_back(mk(1, 2, 3, 0, 0, 0, 7, 0));
        bq.push_back(mk(5, 0, 1, 2, 1, 0, 3, 0));
        bq.push_back(mk(1, 4, 5, 0, 6, 0, 9, 1));
        run_session("misalign", 32'h200, 0, 0);
        check("misalign_addr1", {32'd0, obs_at(1)[63:32]}, 64'h204);
        check("misalign_sticky", {63'd0, err_align}, 64'd1);

        // Word limit without in_last
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(mk(1, i + 1, 0, 0, 0, 0, 32'(i), 0));
        run_session("limit", 32'h300, 2, 0);

        // Address wrap
        bq.delete();
        bq.push_back(mk(7, 1, 0, 0, 0, 0, 32'hABCD_E000, 0));
        bq.push_back(mk(7, 2, 0, 0, 0, 0, 32'h1111_1000, 1));
        run_session("wrap", 32'hFFFF_FFFC, 0, 0);
        check("wrap_addr", {32'd0, obs_at(1)[63:32]}, 64'h0);

        // Asynchronous reset with a write in flight
        @(negedge clk);
        start = 1'b1; base_addr = 32'h500; max_words = 0;
        @(negedge clk);
        start = 1'b0;
        drive(mk(0, 3, 1, 2, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        check("arst_pre_we", {63'd0, mem_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", {63'd0, mem_we}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        check("arst_count", 64'(word_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bq.delete();
        bq.push_back(mk(0, 3, 1, 2, 0, 0, 0, 0));
        bq.push_back(mk(3, 1, 6, 0, 5, 0, 32'hFFFF_FFF0, 1));
        run_session("post_rst", 32'h500, 0, 0);

        // Random sessions
        for (int s = 0; s < 25; s++) begin
            int n;
            bundle_t b;
            bq.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                b.cls = 3'($urandom_range(0, 7));
                b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
                b.f3 = 3'($urandom); b.f7 = 7'($urandom); b.imm = $urandom;
                if ((b.cls == 3'd5 || b.cls == 3'd6) && ($urandom_range(0, 4) != 0)) b.imm[0] = 1'b0;
                b.last = (i == n - 1) || ($urandom_range(0, 9) == 0);
                bq.push_back(b);
            end
            run_session($sformatf("rnd%0d", s), $urandom,
                        ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 6)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Streaming RV32I instruction encoder/writer: the producing end of the main decoder's opcode/format contract.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit words using the same eight classes: R, I, LW, JALR, S, B, J, U (LUI).
- Writes the words sequentially into instruction memory. Used for boot-time program load and for generating directed test programs for the pipeline.

Parameters:
- ADDR_W, 32, instruction memory byte-address width
- CNT_W, 16, width of the word counter and the max_words limit

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- base_addr  in  ADDR_W  first write address; sampled on start
- max_words  in  CNT_W  session word limit; sampled on start; 0 means no limit
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  marks the final bundle of the session
- in_class  in  3  0=R 1=I 2=LW 3=JALR 4=S 5=B 6=J 7=U
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 for R/I/S/B; ignored for the other classes
- in_funct7  in  7  funct7 for R only
- in_imm  in  32  sign-extended byte immediate
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  word-aligned write address
- mem_wdata  out  32  encoded instruction
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at session end
- err_align  out  1  sticky; B/J immediate with imm[0]=1 was rejected
- word_count  out  CNT_W  words written in current/last session

Behaviour:
- Reset values: state IDLE; in_ready, mem_we, busy, done, err_align = 0; mem_addr, mem_wdata, word_count = 0.
- States:
  - IDLE: start -> RUN. On that edge: addr<=base_addr with bits[1:0] forced to 0; word_count<=0; err_align<=0; limit latched.
  - RUN: in_ready = 1 unless the limit is reached (accepted count == max_words and max_words != 0). Transfer on in_valid && in_ready. A transfer with in_last, or the transfer that reaches the limit -> DRAIN.
  - DRAIN: exactly one cycle. Lets the final write retire, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency:
  - Registered output stage: mem_we/mem_addr/mem_wdata are valid the cycle after the transfer.
  - Throughput is one word per cycle.
  - mem_addr advances by 4 after each write. It wraps modulo 2^ADDR_W with no error.
  - word_count increments on each mem_we.
- Encoding (opcodes from the shared package):
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I: imm[11:0]|rs1|funct3|rd|0010011
  - LW: funct3 forced to 010, opcode 0000011
  - JALR: funct3 forced to 000, opcode 1100111
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - U: imm[31:12]|rd|0110111
  - Upper immediate bits beyond each format are silently dropped.
- Misaligned B/J (imm[0]=1):
  - The bundle is consumed and no write occurs.
  - Address and count are unchanged; err_align is set (sticky until next start).
  - in_last on such a bundle still ends the session.
- start while not IDLE is ignored.
- in_valid in IDLE/DRAIN/DONE is not accepted, because in_ready=0 in those states.
- Async reset mid-session: everything returns to reset values immediately. A pending write is lost, and mem_we drops asynchronously.

Decomposition:
- Shared package rv_pkg:
  - opcode constants OP_R, OP_I, OP_LW, OP_JALR, OP_S, OP_B, OP_J, OP_U (same values the decoder uses)
  - class enum
  - state enum
  - F3_LW=010 and F3_JALR=000
- One natural sub-module: rv_imm_pack. Purely combinational; maps class+fields to the 32-bit word plus an align_err flag.
- The top level holds the FSM, address/count registers and the output register.

Test Plan:
- start, base_addr=0x100; R {rd=3, rs1=1, rs2=2, f3=0, f7=0}, in_last -> one write: addr 0x100, data 0x002081B3; then done pulse, word_count=1.
- Back-to-back streaming: I addi x1,x0,5; LW x5,8(x2); S sw x5,12(x2) with in_valid held -> writes on consecutive cycles at 0x0/0x4/0x8, data 0x00500093 / 0x00812283 / 0x00512623.
- Formats: B beq x1,x2,imm=-4 -> 0xFE208EE3; U lui x7,imm=0x12345000 -> 0x123453B7; J jal x1,imm=0x800 -> 0x001000EF.
- Misaligned: B with imm=3 between two valid words -> only 2 writes at consecutive addresses, err_align=1 until the next start.
- Limit: max_words=2 with in_valid held and no in_last -> in_ready drops after 2 transfers, done follows, word_count=2.
- Reset mid-session after 1 write: all outputs 0 and busy=0 immediately; a following start re-runs cleanly. Separately, base_addr=0xFFFFFFFC with 2 words -> second write goes to 0x0.
